// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Run/pause/lap/clear control and 1 ms BCD counting core of
//                the SS.mmm stopwatch (00.000 .. 59.999).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int N        = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_stop,
    input  logic         lap,
    input  logic         clear,
    output logic [N-1:0] count,
    output logic [N-1:0] dec,
    output logic [N-1:0] cent,
    output logic [N-1:0] seg,
    output logic [N-1:0] seg_dec,
    output logic         running,
    output logic         lap_active,
    output logic         ovf
);

    localparam int c_DIV    = CLK_FREQ / TICK_HZ;
    localparam int c_PW     = $clog2(c_DIV);
    localparam int c_DIGITS = 5;
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(c_DIV - 1);
    // Digit 0 is ms units; the top digit is seconds tens and wraps after 5.
    localparam logic [c_DIGITS-1:0][N-1:0] c_DIGIT_MAX =
        {N'(5), N'(9), N'(9), N'(9), N'(9)};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic                         w_snap_load;
    logic                         w_clear_all;
    logic                         w_counting;
    logic                         w_tick;
    logic [c_PW-1:0]              r_presc;
    logic [c_DIGITS-1:0][N-1:0]   r_live;
    logic [c_DIGITS-1:0][N-1:0]   r_snap;
    logic [c_DIGITS-1:0][N-1:0]   w_disp;
    logic [c_DIGITS:0]            w_carry;
    logic                         r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Priority clear > start_stop > lap; lower-priority pulses are dropped.
    always_comb begin
        w_next_state = r_state;
        w_snap_load  = 1'b0;
        w_clear_all  = 1'b0;
        if (clear) begin
            w_next_state = S_IDLE;
            w_clear_all  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_stop) w_next_state = S_RUN;
                end
                S_RUN: begin
                    if (start_stop) begin
                        w_next_state = S_PAUSE;
                    end else if (lap) begin
                        w_next_state = S_LAP;
                        w_snap_load  = 1'b1;
                    end
                end
                S_LAP: begin
                    if (start_stop)  w_next_state = S_PAUSE;
                    else if (lap)    w_next_state = S_RUN;
                end
                S_PAUSE: begin
                    if (start_stop) w_next_state = S_RUN;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == c_PRE_MAX);

    // Prescaler holds through PAUSE so a resume continues the partial tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                r_presc <= '0;
        else if (w_clear_all || r_state == S_IDLE) r_presc <= '0;
        else if (w_counting)                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end

    // w_carry[i] is the increment request into digit i; w_carry[top] is the wrap.
    always_comb begin
        logic l_c;
        l_c     = w_tick;
        w_carry = '0;
        for (int i = 0; i < c_DIGITS; i++) begin
            w_carry[i] = l_c;
            l_c        = l_c && (r_live[i] == c_DIGIT_MAX[i]);
        end
        w_carry[c_DIGITS] = l_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live <= '0;
        end else if (w_clear_all) begin
            r_live <= '0;
        end else begin
            for (int i = 0; i < c_DIGITS; i++) begin
                if (w_carry[i])
                    r_live[i] <= (r_live[i] == c_DIGIT_MAX[i]) ? '0 : r_live[i] + 1'b1;
            end
        end
    end

    // Snapshot captures the pre-increment value when a tick coincides with lap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_snap <= '0;
        else if (w_clear_all) r_snap <= '0;
        else if (w_snap_load) r_snap <= r_live;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_ovf <= 1'b0;
        else if (w_clear_all) r_ovf <= 1'b0;
        else                  r_ovf <= w_carry[c_DIGITS];
    end

    assign w_disp     = (r_state == S_LAP) ? r_snap : r_live;
    assign count      = w_disp[0];
    assign dec        = w_disp[1];
    assign cent       = w_disp[2];
    assign seg        = w_disp[3];
    assign seg_dec    = w_disp[4];
    assign running    = w_counting;
    assign lap_active = (r_state == S_LAP);
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed self-checking bench for stopwatch_ctrl; u_dut uses
//                DIV=10, u_dut_fast uses DIV=2 for the long carry/wrap runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst;
    logic       start_stop;
    logic       start_stop_fast;
    logic       lap;
    logic       clear;
    logic [3:0] count, dec, cent, seg, seg_dec;
    logic [3:0] count_f, dec_f, cent_f, seg_f, seg_dec_f;
    logic       running, lap_active, ovf;
    logic       running_f, lap_active_f, ovf_f;
    logic [19:0] w_digits;
    logic [19:0] w_digits_f;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_ctrl #(.CLK_FREQ(10), .TICK_HZ(1), .N(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .count      (count),
        .dec        (dec),
        .cent       (cent),
        .seg        (seg),
        .seg_dec    (seg_dec),
        .running    (running),
        .lap_active (lap_active),
        .ovf        (ovf)
    );

    stopwatch_ctrl #(.CLK_FREQ(2), .TICK_HZ(1), .N(4)) u_dut_fast (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop_fast),
        .lap        (lap),
        .clear      (clear),
        .count      (count_f),
        .dec        (dec_f),
        .cent       (cent_f),
        .seg        (seg_f),
        .seg_dec    (seg_dec_f),
        .running    (running_f),
        .lap_active (lap_active_f),
        .ovf        (ovf_f)
    );

    // Packed as SS.mmm BCD so expected values read naturally in hex.
    assign w_digits   = {seg_dec, seg, cent, dec, count};
    assign w_digits_f = {seg_dec_f, seg_f, cent_f, dec_f, count_f};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        start_stop      = 1'b0;
        start_stop_fast = 1'b0;
        lap             = 1'b0;
        clear           = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        check("rst_digits",  w_digits,   20'h00000);
        check("rst_running", running,    1'b0);
        check("rst_lap",     lap_active, 1'b0);
        check("rst_ovf",     ovf,        1'b0);

        // Run 30 clocks: ticks land on the 10th, 20th, 30th edges.
        pulse_ss();
        step(29);
        check("run29_digits", w_digits, 20'h00002);
        step(1);
        check("run30_digits", w_digits, 20'h00003);
        check("run_running",  running,  1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_digits",  w_digits, 20'h00000);
        check("async_rst_running", running,  1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lap freeze and release.
        pulse_ss();
        step(50);
        check("pre_lap_digits", w_digits, 20'h00005);
        pulse_lap();
        check("lap_active_on", lap_active, 1'b1);
        check("lap_running",   running,    1'b1);
        step(50);
        check("lap_frozen", w_digits, 20'h00005);
        pulse_lap();
        check("lap_release_digits", w_digits,   20'h00010);
        check("lap_active_off",     lap_active, 1'b0);

        // Prescaler is 2 after the release edge; two more edges bring it to 4.
        step(2);
        pulse_ss();
        check("pause_running", running,  1'b0);
        check("pause_digits",  w_digits, 20'h00010);
        step(100);
        check("pause_hold", w_digits, 20'h00010);
        pulse_ss();
        step(4);
        check("resume_5clk", w_digits, 20'h00010);
        step(1);
        check("resume_6clk", w_digits, 20'h00011);

        // clear beats start_stop; start_stop beats lap.
        clear      = 1'b1;
        start_stop = 1'b1;
        step(1);
        clear      = 1'b0;
        start_stop = 1'b0;
        check("clr_digits",  w_digits, 20'h00000);
        check("clr_running", running,  1'b0);
        start_stop = 1'b1;
        lap        = 1'b1;
        step(1);
        start_stop = 1'b0;
        lap        = 1'b0;
        check("ss_lap_running", running,    1'b1);
        check("ss_lap_lapact",  lap_active, 1'b0);
        step(10);
        check("after_clr_count", w_digits, 20'h00001);

        // Long runs on the DIV=2 instance: a tick every second edge.
        start_stop_fast = 1'b1;
        step(1);
        start_stop_fast = 1'b0;
        step(19998);
        check("fast_09999", w_digits_f, 20'h09999);
        step(2);
        check("fast_10000", w_digits_f, 20'h10000);
        step(99998);
        check("fast_59999",     w_digits_f, 20'h59999);
        check("fast_ovf_pre",   ovf_f,      1'b0);
        step(1);
        check("fast_ovf_early", ovf_f,      1'b0);
        step(1);
        check("wrap_digits", w_digits_f, 20'h00000);
        check("wrap_ovf",    ovf_f,      1'b1);
        step(1);
        check("wrap_ovf_drop", ovf_f,      1'b0);
        step(1);
        check("wrap_continue", w_digits_f, 20'h00001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
